// File: rtl/riscv_dcache_fsm_if.sv
// riscv_dcache_fsm_if
//   Groups the core request, tag-array and main-memory handshake signals of
//   the data-cache controller.
//   master : the cache controller (consumes requests/flags, drives strobes)
//   slave  : the surrounding core / tag array / memory side
// Signals:
//   cpu_rden, cpu_wren       core load / store request
//   hit, dirty               tag array flags for the current index/tag
//   mem_ready                memory finished the current read or write
//   stall                    freezes the core pipeline
//   mem_wren, mem_rden       victim write-back / line-fill request
//   tag_sel                  1: memory address uses tag_old, 0: core tag
//   replace_tag              tag/valid/dirty write strobe to the tag array
//   set_valid, set_dirty     tag array valid_in / dirty_in
//   dcache_wren              write core store data into the data array
//   fill                     write memory line into the data array
interface riscv_dcache_fsm_if;
  logic cpu_rden;
  logic cpu_wren;
  logic hit;
  logic dirty;
  logic mem_ready;
  logic stall;
  logic mem_wren;
  logic mem_rden;
  logic tag_sel;
  logic replace_tag;
  logic set_valid;
  logic set_dirty;
  logic dcache_wren;
  logic fill;

  modport master (
    input  cpu_rden, cpu_wren, hit, dirty, mem_ready,
    output stall, mem_wren, mem_rden, tag_sel, replace_tag,
           set_valid, set_dirty, dcache_wren, fill
  );

  modport slave (
    output cpu_rden, cpu_wren, hit, dirty, mem_ready,
    input  stall, mem_wren, mem_rden, tag_sel, replace_tag,
           set_valid, set_dirty, dcache_wren, fill
  );
endinterface

// File: rtl/riscv_dcache_fsm.sv
// riscv_dcache_fsm
//   Data-cache miss controller sitting downstream of the tag array. Stalls
//   the core on a miss, writes back a dirty victim, allocates the new line
//   and lets the request retry as a hit. Outputs are Mealy (state + inputs)
//   so tag-array strobes are stable through the high phase, ahead of the
//   array's negedge write.
// Ports:
//   clk         system clock (posedge)
//   rst         asynchronous active-high reset
//   bus         riscv_dcache_fsm_if.master (request, flags, strobes)
//   hit_count   saturating count of counted hit requests
//   miss_count  saturating count of miss requests
// Configuration:
//   DCACHE_PERF_CNT_EN  when defined, builds the hit/miss counters;
//                       otherwise both counters are tied to 0.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | serve hits; detect misses and pick write-back or allocate
// WRITE_BACK | write dirty victim line to memory (tag_old address)
// ALLOCATE   | read new line from memory, fill and retag on mem_ready
module riscv_dcache_fsm #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_dcache_fsm_if.master   bus,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic req;
  logic is_store;

  assign req      = bus.cpu_rden | bus.cpu_wren;
  // A simultaneous load and store is handled as a store.
  assign is_store = bus.cpu_wren;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req && !bus.hit) begin
          state_d = bus.dirty ? WRITE_BACK : ALLOCATE;
        end
      end
      WRITE_BACK: begin
        if (bus.mem_ready) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (bus.mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.stall       = 1'b0;
    bus.mem_wren    = 1'b0;
    bus.mem_rden    = 1'b0;
    bus.tag_sel     = 1'b0;
    bus.replace_tag = 1'b0;
    bus.set_valid   = 1'b0;
    bus.set_dirty   = 1'b0;
    bus.dcache_wren = 1'b0;
    bus.fill        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (bus.hit) begin
            // Store hit rewrites the same tag with dirty set.
            if (is_store) begin
              bus.dcache_wren = 1'b1;
              bus.replace_tag = 1'b1;
              bus.set_valid   = 1'b1;
              bus.set_dirty   = 1'b1;
            end
          end else begin
            bus.stall = 1'b1;
          end
        end
      end
      WRITE_BACK: begin
        bus.stall    = 1'b1;
        bus.mem_wren = 1'b1;
        bus.tag_sel  = 1'b1;
      end
      ALLOCATE: begin
        bus.stall    = 1'b1;
        bus.mem_rden = 1'b1;
        // Fresh line is clean; a pending store marks it dirty on retry.
        if (bus.mem_ready) begin
          bus.fill        = 1'b1;
          bus.replace_tag = 1'b1;
          bus.set_valid   = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  logic             retry_q;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  // retry marks the post-allocate IDLE cycle so the re-evaluated request
  // is not counted a second time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_q <= 1'b0;
    end else if (state_q == ALLOCATE && bus.mem_ready) begin
      retry_q <= 1'b1;
    end else if (state_q == IDLE) begin
      retry_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == IDLE && req && !retry_q) begin
      if (bus.hit) begin
        if (hit_cnt_q != '1) begin
          hit_cnt_q <= hit_cnt_q + 1'b1;
        end
      end else begin
        if (miss_cnt_q != '1) begin
          miss_cnt_q <= miss_cnt_q + 1'b1;
        end
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
